// File: rtl/assoc_pkg.sv
// Shared defaults, FSM encoding and index-width helper for the associative-memory scoring back-end.
package assoc_pkg;
  localparam int DEF_NUM_CLASS = 26;
  localparam int DEF_IN_W      = 5;
  localparam int DEF_NUM_SEG   = 16;
  localparam int DEF_ACC_W     = DEF_IN_W + $clog2(DEF_NUM_SEG);
  localparam int DEF_CLS_W     = $clog2(DEF_NUM_CLASS);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  function automatic int cls_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/assoc_acc_bank.sv
// Per-class score accumulators with add-enable, clear and a read mux for the argmax scan.
// Define ASSOC_ACC_SAT_EN to clamp at 2^ACC_W-1; otherwise accumulators wrap.
module assoc_acc_bank import assoc_pkg::*; #(
  parameter int NUM_CLASS = DEF_NUM_CLASS,
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int CLS_W     = DEF_CLS_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      add_en,
  input  logic                      clr,
  input  logic [NUM_CLASS*IN_W-1:0] in_scores,
  input  logic [CLS_W-1:0]          rd_idx,
  output logic [ACC_W-1:0]          rd_data
);
  logic [NUM_CLASS-1:0][ACC_W-1:0] acc_q, acc_d;
`ifdef ASSOC_ACC_SAT_EN
  logic [ACC_W:0]   sum;
`else
  logic [ACC_W-1:0] sum;
`endif

  always_comb begin
    acc_d = acc_q;
    sum   = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
`ifdef ASSOC_ACC_SAT_EN
      sum = {1'b0, acc_q[k]} + (ACC_W+1)'(in_scores[k*IN_W +: IN_W]);
`else
      sum = acc_q[k] + ACC_W'(in_scores[k*IN_W +: IN_W]);
`endif
      if (clr) begin
        acc_d[k] = '0;
      end else if (add_en) begin
`ifdef ASSOC_ACC_SAT_EN
        // A clamped value plus any non-zero score carries out again, so it stays clamped.
        acc_d[k] = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_d[k] = sum;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Indices past NUM_CLASS-1 read as zero rather than X.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CLASS; k++)
      if (rd_idx == CLS_W'(k)) rd_data = acc_q[k];
  end
endmodule

// File: rtl/assoc_argmax_seq.sv
// Accumulates per-class popcount scores over a query, then scans one class per cycle for the argmax.
// Optional build macro ASSOC_ACC_SAT_EN selects saturating accumulators (see assoc_acc_bank).
module assoc_argmax_seq import assoc_pkg::*; #(
  parameter int NUM_CLASS = DEF_NUM_CLASS,
  parameter int IN_W      = DEF_IN_W,
  parameter int NUM_SEG   = DEF_NUM_SEG,
  parameter int ACC_W     = IN_W + $clog2(NUM_SEG),
  localparam int CLS_W    = cls_w(NUM_CLASS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [NUM_CLASS*IN_W-1:0] in_scores,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CLS_W-1:0]          out_class,
  output logic [ACC_W-1:0]          out_score,
  output logic                      busy
);
  state_e             state_q, state_d;
  logic [CLS_W-1:0]   idx_q, idx_d;
  logic [CLS_W-1:0]   best_idx_q, best_idx_d;
  logic [ACC_W-1:0]   best_score_q, best_score_d;
  logic [ACC_W-1:0]   rd_data;
  logic               add_en, clr;

  assoc_acc_bank #(
    .NUM_CLASS(NUM_CLASS), .IN_W(IN_W), .ACC_W(ACC_W), .CLS_W(CLS_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .add_en    (add_en),
    .clr       (clr),
    .in_scores (in_scores),
    .rd_idx    (idx_q),
    .rd_data   (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    add_en       = 1'b0;
    clr          = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          add_en = 1'b1;
          if (in_last) begin
            state_d = ST_SCAN;
            idx_d   = '0;
          end
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (idx_q == '0 || rd_data > best_score_q) begin
          best_idx_d   = idx_q;
          best_score_d = rd_data;
        end
        if (idx_q == CLS_W'(NUM_CLASS-1)) state_d = ST_OUT;
        else                              idx_d   = idx_q + CLS_W'(1);
      end
      ST_OUT: begin
        if (out_ready) begin
          clr     = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_ACCUM);
  assign out_class = best_idx_q;
  assign out_score = best_score_q;
endmodule

// File: tb/tb_assoc_argmax_seq.sv
// Self-checking bench: directed table, hand-written corner sequences and random queries vs a reference model.
module tb_assoc_argmax_seq;
  localparam int NUM_CLASS = 26;
  localparam int IN_W      = 5;
  localparam int NUM_SEG   = 16;
  localparam int ACC_W     = 9;
  localparam int CLS_W     = 5;
  localparam int ACC_MAX   = (1 << ACC_W) - 1;
`ifdef ASSOC_ACC_SAT_EN
  localparam int OVF_EXP = 511;
`else
  localparam int OVF_EXP = 108;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid, in_ready, in_last;
  logic [NUM_CLASS*IN_W-1:0] in_scores;
  logic                      out_valid, out_ready, busy;
  logic [CLS_W-1:0]          out_class;
  logic [ACC_W-1:0]          out_score;

  assoc_argmax_seq #(.NUM_CLASS(NUM_CLASS), .IN_W(IN_W), .NUM_SEG(NUM_SEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_scores(in_scores), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int beat_sc[64][NUM_CLASS];

  typedef struct {
    string nm;
    int    nb, base, ca, va, cb, vb;
    int    exp_cls, exp_sc;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int nb, input int base, input int ca, input int va,
                      input int cb, input int vb);
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < NUM_CLASS; k++)
        beat_sc[b][k] = (k == ca) ? va : (k == cb) ? vb : base;
  endtask

  // Reference: plain per-class sums, then the first index holding the maximum.
  task automatic ref_q(input int nb, output int cls, output int sc);
    int tot[NUM_CLASS];
    for (int k = 0; k < NUM_CLASS; k++) begin
      tot[k] = 0;
      for (int b = 0; b < nb; b++) begin
`ifdef ASSOC_ACC_SAT_EN
        tot[k] = tot[k] + beat_sc[b][k];
        if (tot[k] > ACC_MAX) tot[k] = ACC_MAX;
`else
        tot[k] = (tot[k] + beat_sc[b][k]) % (ACC_MAX + 1);
`endif
      end
    end
    cls = 0; sc = tot[0];
    for (int k = 1; k < NUM_CLASS; k++)
      if (tot[k] > sc) begin cls = k; sc = tot[k]; end
  endtask

  task automatic send_beats(input string nm, input int nb);
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      for (int k = 0; k < NUM_CLASS; k++) in_scores[k*IN_W +: IN_W] = beat_sc[b][k][IN_W-1:0];
      if (b == 0) chk({nm, " in_ready"}, int'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_q(input string nm, input int nb, input int ec, input int es);
    int cyc;
    send_beats(nm, nb);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, cyc, NUM_CLASS);
    if (out_valid === 1'b1) begin
      chk({nm, " class"}, int'(out_class), ec);
      chk({nm, " score"}, int'(out_score), es);
      chk({nm, " in_ready@out"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, int'(out_valid), 0);
    chk({nm, " in_ready back"}, int'(in_ready), 1);
  endtask

  initial begin
    vec_t tbl[6];
    int   c, s, cls0, sc0;
    bit   rose;

    tbl[0] = '{"single",   1, 16, 2, 17, 2, 17,  2, 17};
    tbl[1] = '{"seg16",   16, 30, 25, 31, 25, 31, 25, 496};
    tbl[2] = '{"tie",      2, 10, 3, 20, 7, 20,  3, 40};
    tbl[3] = '{"overflow",20,  0, 0, 31, 0, 31,  0, OVF_EXP};
    tbl[4] = '{"zero",     1,  0, 0, 0, 0, 0,    0, 0};
    tbl[5] = '{"last_cls", 3,  1, 25, 2, 24, 2, 24, 6};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_scores = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_class", int'(out_class), 0);
    chk("rst out_score", int'(out_score), 0);
    chk("rst busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst in_ready", int'(in_ready), 1);

    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].nb, tbl[i].base, tbl[i].ca, tbl[i].va, tbl[i].cb, tbl[i].vb);
      run_q(tbl[i].nm, tbl[i].nb, tbl[i].exp_cls, tbl[i].exp_sc);
    end

    // Backpressure: result held while junk beats arrive; they must not accumulate.
    fill(1, 0, 5, 9, 5, 9);
    send_beats("bp", 1);
    repeat (NUM_CLASS) @(negedge clk);
    chk("bp out_valid", int'(out_valid), 1);
    cls0 = int'(out_class); sc0 = int'(out_score);
    chk("bp class", cls0, 5);
    chk("bp score", sc0, 9);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_last  = 1'b1;
      in_scores = {NUM_CLASS{5'd31}};
      @(negedge clk);
      chk("bp hold valid", int'(out_valid), 1);
      chk("bp hold class", int'(out_class), 5);
      chk("bp hold score", int'(out_score), 9);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp busy", int'(busy), 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    fill(1, 0, 0, 0, 0, 0);
    run_q("bp zero", 1, 0, 0);

    // Reset while scanning idx 10: nothing emitted, outputs back to zero.
    fill(1, 16, 2, 17, 2, 17);
    send_beats("midrst", 1);
    repeat (10) @(negedge clk);
    chk("midrst busy pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst out_class", int'(out_class), 0);
    chk("midrst out_score", int'(out_score), 0);
    chk("midrst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) rose = 1'b1;
    end
    chk("midrst no result", int'(rose), 0);
    fill(1, 0, 5, 9, 5, 9);
    run_q("after rst", 1, 5, 9);

    // Random queries against the reference model.
    for (int q = 0; q < 40; q++) begin
      int nb;
      bit narrow;
      nb = $urandom_range(1, 20);
      narrow = $urandom_range(0, 1);
      for (int b = 0; b < nb; b++)
        for (int k = 0; k < NUM_CLASS; k++)
          beat_sc[b][k] = narrow ? $urandom_range(0, 2) : $urandom_range(0, 31);
      ref_q(nb, c, s);
      run_q($sformatf("rand%0d", q), nb, c, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
